// File: rtl/sbqm_sensor_front.sv
// sbqm_sensor_front
//
// Photocell conditioner placed in front of the bank-queue Unit. Both raw,
// asynchronous, active-low door sensors are synchronised, debounced and
// converted into single clean low pulses. Arrivals and departures are queued
// in small pending counters and replayed one at a time, so the outputs never
// overlap and always keep a minimum high gap between pulses.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high reset
//   rawUp      - entry photocell, asynchronous, low = beam broken
//   rawDown    - exit photocell, asynchronous, low = beam broken
//   upSignal   - registered entry event, idles high, one low pulse per arrival
//   downSignal - registered exit event, idles high, one low pulse per departure
//   overflow   - sticky flag, set when an event is lost to a full pending counter
//
// Parameters:
//   DEBOUNCE  - synchronised cycles a new level must hold to be accepted (>=2)
//   PULSE_LOW - cycles each output pulse stays low (>=1)
//   PULSE_GAP - minimum high cycles between any two output pulses (>=1)
module sbqm_sensor_front #(
  parameter int DEBOUNCE  = 4,
  parameter int PULSE_LOW = 2,
  parameter int PULSE_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rawUp,
  input  logic rawDown,
  output logic upSignal,
  output logic downSignal,
  output logic overflow
);

  localparam int DBW  = $clog2(DEBOUNCE) + 1;
  localparam int TMAX = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Channel 0 is the entry (up) side, channel 1 the exit (down) side.
  logic [1:0] raw_in;
  logic [1:0] fall_evt;
  logic [1:0] pend_any;
  logic [1:0] drop;
  logic [1:0] launch;

  assign raw_in = {rawDown, rawUp};

  // ---------------------------------------------------------------------
  // Per-channel synchroniser, debouncer and pending-event counter
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic           s1_reg;
    logic           s2_reg;
    logic           stable_reg;
    logic [DBW-1:0] db_cnt_reg;
    logic [1:0]     pend_reg;
    logic           db_done;

    // The edge on which the mismatch count would reach DEBOUNCE.
    assign db_done      = (s2_reg != stable_reg) && (db_cnt_reg == DBW'(DEBOUNCE - 1));
    // Only an accepted high-to-low change of the debounced level is an event.
    assign fall_evt[gi] = db_done && stable_reg;
    assign pend_any[gi] = (pend_reg != 2'd0);
    // A launch on the same edge frees a slot, so only then is a full counter safe.
    assign drop[gi]     = fall_evt[gi] && !launch[gi] && (pend_reg == 2'd3);

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_reg     <= 1'b1;
        s2_reg     <= 1'b1;
        stable_reg <= 1'b1;
        db_cnt_reg <= '0;
        pend_reg   <= 2'd0;
      end else begin
        s1_reg <= raw_in[gi];
        s2_reg <= s1_reg;

        if (s2_reg == stable_reg) begin
          db_cnt_reg <= '0;
        end else if (db_done) begin
          stable_reg <= s2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end

        // Event and launch together cancel; a full counter simply holds.
        if (fall_evt[gi] && !launch[gi]) begin
          if (pend_reg != 2'd3) begin
            pend_reg <= pend_reg + 2'd1;
          end
        end else if (!fall_evt[gi] && launch[gi]) begin
          pend_reg <= pend_reg - 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (|drop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

  // ---------------------------------------------------------------------
  // Output sequencer
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_LOW   = 2'd1,
    DOWN_LOW = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  tmr_reg, tmr_next;
  logic           last_up_reg, last_up_next;
  logic           pick_up, pick_down;
  logic           arb;
  logic           up_sig_reg, down_sig_reg;

  // Channel choice: a lone requester wins; on a tie, serve the side that
  // was not served last (up first after reset).
  always_comb begin
    pick_up   = 1'b0;
    pick_down = 1'b0;
    if (pend_any[0] && pend_any[1]) begin
      if (last_up_reg) begin
        pick_down = 1'b1;
      end else begin
        pick_up = 1'b1;
      end
    end else if (pend_any[0]) begin
      pick_up = 1'b1;
    end else if (pend_any[1]) begin
      pick_down = 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tmr_next     = tmr_reg;
    last_up_next = last_up_reg;
    launch       = 2'b00;
    arb          = 1'b0;

    case (state_reg)
      IDLE: begin
        arb = 1'b1;
      end
      UP_LOW, DOWN_LOW: begin
        if (tmr_reg == TW'(PULSE_LOW - 1)) begin
          state_next = GAP;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      GAP: begin
        // Leaving GAP passes through IDLE's decision in the same edge so that
        // back-to-back pulses keep exactly PULSE_GAP high cycles between them.
        if (tmr_reg == TW'(PULSE_GAP - 1)) begin
          state_next = IDLE;
          tmr_next   = '0;
          arb        = 1'b1;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tmr_next   = '0;
      end
    endcase

    if (arb) begin
      if (pick_up) begin
        state_next   = UP_LOW;
        tmr_next     = '0;
        launch       = 2'b01;
        last_up_next = 1'b1;
      end else if (pick_down) begin
        state_next   = DOWN_LOW;
        tmr_next     = '0;
        launch       = 2'b10;
        last_up_next = 1'b0;
      end
    end
  end

  // Outputs are decoded from the next state so the low level appears on the
  // same edge as the launch, yet still comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tmr_reg      <= '0;
      last_up_reg  <= 1'b0;
      up_sig_reg   <= 1'b1;
      down_sig_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tmr_reg      <= tmr_next;
      last_up_reg  <= last_up_next;
      up_sig_reg   <= (state_next != UP_LOW);
      down_sig_reg <= (state_next != DOWN_LOW);
    end
  end

  assign upSignal   = up_sig_reg;
  assign downSignal = down_sig_reg;

endmodule

// File: tb/tb_sbqm_sensor_front.sv
// Testbench for sbqm_sensor_front.
// dut_a uses the default timing; dut_b stretches PULSE_LOW so that events can
// be entered faster than the sequencer drains them.
module tb_sbqm_sensor_front;

  typedef struct packed {
    logic [1:0]  ch;     // 1 = upSignal, 2 = downSignal
    logic [31:0] start;  // edge index of the first low cycle
    logic [31:0] len;    // number of low cycles
  } pulse_t;

  logic clk = 1'b0;
  logic reset_a, raw_up_a, raw_down_a, up_a, down_a, ovf_a;
  logic reset_b, raw_up_b, raw_down_b, up_b, down_b, ovf_b;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int both_low_a = 0;
  int both_low_b = 0;

  pulse_t exp_a[$];
  pulse_t obs_a[$];
  pulse_t exp_b[$];
  pulse_t obs_b[$];

  sbqm_sensor_front dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .rawUp      (raw_up_a),
    .rawDown    (raw_down_a),
    .upSignal   (up_a),
    .downSignal (down_a),
    .overflow   (ovf_a)
  );

  sbqm_sensor_front #(
    .DEBOUNCE  (4),
    .PULSE_LOW (64),
    .PULSE_GAP (4)
  ) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .rawUp      (raw_up_b),
    .rawDown    (raw_down_b),
    .upSignal   (up_b),
    .downSignal (down_b),
    .overflow   (ovf_b)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Pulse monitor: records every completed low pulse on all four outputs.
  initial begin
    int     plen[4];
    int     pst[4];
    logic [3:0] s;
    pulse_t p;
    for (int j = 0; j < 4; j++) begin
      plen[j] = 0;
      pst[j]  = 0;
    end
    forever begin
      @(negedge clk);
      s = {down_b, up_b, down_a, up_a};
      if (up_a === 1'b0 && down_a === 1'b0) both_low_a++;
      if (up_b === 1'b0 && down_b === 1'b0) both_low_b++;
      for (int j = 0; j < 4; j++) begin
        if (s[j] === 1'b0) begin
          if (plen[j] == 0) pst[j] = cyc;
          plen[j]++;
        end else if (plen[j] != 0) begin
          p.ch    = 2'(j % 2 + 1);
          p.start = pst[j];
          p.len   = plen[j];
          if (j < 2) obs_a.push_back(p);
          else       obs_b.push_back(p);
          plen[j] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs_a(input int n, input int budget);
    for (int i = 0; i < budget && obs_a.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_obs_b(input int n, input int budget);
    for (int i = 0; i < budget && obs_b.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_a = 1'b1; raw_up_a = 1'b1; raw_down_a = 1'b1;
    reset_b = 1'b1; raw_up_b = 1'b1; raw_down_b = 1'b1;
    tick(3);
    checks++;
    if ({up_a, down_a, ovf_a} !== 3'b110)
      $display("FAIL reset_a: up/down/ovf=%b, expected 110", {up_a, down_a, ovf_a});
    else passes++;
    checks++;
    if ({up_b, down_b, ovf_b} !== 3'b110)
      $display("FAIL reset_b: up/down/ovf=%b, expected 110", {up_b, down_b, ovf_b});
    else passes++;
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick(20);
    checks++;
    if ({up_a, down_a, ovf_a} !== 3'b110)
      $display("FAIL idle_levels: up/down/ovf=%b, expected 110", {up_a, down_a, ovf_a});
    else passes++;
    checks++;
    if (obs_a.size() + obs_b.size() !== 0)
      $display("FAIL idle_pulses: %0d pulses, expected 0", obs_a.size() + obs_b.size());
    else passes++;
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_single_up();
    int c;
    pulse_t e, o;
    @(negedge clk);
    c = cyc;
    raw_up_a = 1'b0;
    exp_a.push_back('{ch: 2'd1, start: 32'(c + 7), len: 32'd2});
    tick(10);
    raw_up_a = 1'b1;
    wait_obs_a(1, 40);
    tick(10);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() == 0)
        $display("FAIL single_up: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_a.pop_front();
        if (o !== e)
          $display("FAIL single_up: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_a.size() !== 0) $display("FAIL single_up_extra: %0d extra pulses, expected 0", obs_a.size());
    else passes++;
    $display("test_single_up done at cycle %0d", cyc);
  endtask

  task automatic test_glitch_bounce();
    int c;
    pulse_t e, o;
    @(negedge clk);
    raw_down_a = 1'b0;
    tick(3);
    raw_down_a = 1'b1;
    tick(12);
    for (int i = 0; i < 8; i++) begin
      raw_down_a = logic'(i % 2);
      tick(1);
    end
    c = cyc;
    raw_down_a = 1'b0;
    exp_a.push_back('{ch: 2'd2, start: 32'(c + 7), len: 32'd2});
    tick(10);
    raw_down_a = 1'b1;
    wait_obs_a(1, 40);
    tick(10);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() == 0)
        $display("FAIL glitch_bounce: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_a.pop_front();
        if (o !== e)
          $display("FAIL glitch_bounce: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_a.size() !== 0) $display("FAIL glitch_bounce_extra: %0d extra pulses, expected 0", obs_a.size());
    else passes++;
    $display("test_glitch_bounce done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int c;
    pulse_t e, o;
    @(negedge clk);
    c = cyc;
    raw_up_a = 1'b0;
    raw_down_a = 1'b0;
    exp_a.push_back('{ch: 2'd1, start: 32'(c + 7), len: 32'd2});
    exp_a.push_back('{ch: 2'd2, start: 32'(c + 11), len: 32'd2});
    tick(10);
    raw_up_a = 1'b1;
    raw_down_a = 1'b1;
    wait_obs_a(2, 40);
    tick(10);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() == 0)
        $display("FAIL back_to_back: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_a.pop_front();
        if (o !== e)
          $display("FAIL back_to_back: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_a.size() !== 0) $display("FAIL back_to_back_extra: %0d extra pulses, expected 0", obs_a.size());
    else passes++;
    checks++;
    if (both_low_a !== 0) $display("FAIL both_low_a: %0d cycles with both low, expected 0", both_low_a);
    else passes++;
    $display("test_back_to_back done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int c;
    pulse_t e, o;
    @(negedge clk);
    c = cyc;
    raw_up_a = 1'b0;
    raw_down_a = 1'b0;
    exp_a.push_back('{ch: 2'd1, start: 32'(c + 7), len: 32'd2});
    tick(5);
    raw_up_a = 1'b1;
    raw_down_a = 1'b1;
    tick(3);
    checks++;
    if (up_a !== 1'b0) $display("FAIL reset_mid_low: upSignal=%b in second pulse cycle, expected 0", up_a);
    else passes++;
    reset_a = 1'b1;
    tick(1);
    checks++;
    if ({up_a, down_a, ovf_a} !== 3'b110)
      $display("FAIL reset_mid_edge: up/down/ovf=%b, expected 110", {up_a, down_a, ovf_a});
    else passes++;
    tick(1);
    reset_a = 1'b0;
    tick(30);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() == 0)
        $display("FAIL reset_mid: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_a.pop_front();
        if (o !== e)
          $display("FAIL reset_mid: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_a.size() !== 0) $display("FAIL reset_mid_extra: %0d pulses after reset, expected 0", obs_a.size());
    else passes++;
    $display("test_reset_mid done at cycle %0d", cyc);
  endtask

  task automatic test_overflow();
    int c;
    pulse_t e, o;
    reset_b = 1'b1;
    tick(2);
    reset_b = 1'b0;
    tick(2);
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 4; k++)
      exp_b.push_back('{ch: 2'd1, start: 32'(c + 7 + 68 * k), len: 32'd64});
    for (int ev = 0; ev < 5; ev++) begin
      raw_up_b = 1'b0;
      tick(6);
      raw_up_b = 1'b1;
      tick(6);
      if (ev == 3) begin
        checks++;
        if (ovf_b !== 1'b0) $display("FAIL overflow_early: overflow=%b with pendUp at 3, expected 0", ovf_b);
        else passes++;
      end
    end
    checks++;
    if (ovf_b !== 1'b1) $display("FAIL overflow_set: overflow=%b after fifth event, expected 1", ovf_b);
    else passes++;
    wait_obs_b(4, 400);
    tick(80);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0)
        $display("FAIL overflow_pulse: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_b.pop_front();
        if (o !== e)
          $display("FAIL overflow_pulse: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_b.size() !== 0) $display("FAIL overflow_extra: %0d extra pulses, expected 0", obs_b.size());
    else passes++;
    checks++;
    if (ovf_b !== 1'b1) $display("FAIL overflow_sticky: overflow=%b at end, expected 1", ovf_b);
    else passes++;
    $display("test_overflow done at cycle %0d", cyc);
  endtask

  task automatic test_reset_pending();
    int c;
    pulse_t e, o;
    reset_b = 1'b1;
    tick(2);
    checks++;
    if (ovf_b !== 1'b0) $display("FAIL overflow_clear: overflow=%b after reset, expected 0", ovf_b);
    else passes++;
    reset_b = 1'b0;
    tick(2);
    @(negedge clk);
    c = cyc;
    raw_up_b = 1'b0;
    exp_b.push_back('{ch: 2'd1, start: 32'(c + 7), len: 32'd34});
    tick(6);
    raw_up_b = 1'b1;
    tick(6);
    for (int k = 0; k < 2; k++) begin
      raw_down_b = 1'b0;
      tick(6);
      raw_down_b = 1'b1;
      tick(6);
    end
    tick(4);
    checks++;
    if (up_b !== 1'b0) $display("FAIL pend_busy: upSignal=%b before reset, expected 0", up_b);
    else passes++;
    reset_b = 1'b1;
    tick(1);
    checks++;
    if ({up_b, down_b} !== 2'b11) $display("FAIL pend_reset_edge: up/down=%b, expected 11", {up_b, down_b});
    else passes++;
    tick(1);
    reset_b = 1'b0;
    tick(150);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0)
        $display("FAIL pend_reset: no pulse, expected ch=%0d start=%0d len=%0d", e.ch, e.start, e.len);
      else begin
        o = obs_b.pop_front();
        if (o !== e)
          $display("FAIL pend_reset: got ch=%0d start=%0d len=%0d, expected ch=%0d start=%0d len=%0d",
                   o.ch, o.start, o.len, e.ch, e.start, e.len);
        else passes++;
      end
    end
    checks++;
    if (obs_b.size() !== 0) $display("FAIL pend_reset_extra: %0d pulses after reset, expected 0", obs_b.size());
    else passes++;
    checks++;
    if (ovf_b !== 1'b0) $display("FAIL pend_reset_ovf: overflow=%b, expected 0", ovf_b);
    else passes++;
    checks++;
    if (both_low_b !== 0) $display("FAIL both_low_b: %0d cycles with both low, expected 0", both_low_b);
    else passes++;
    $display("test_reset_pending done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_glitch_bounce();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_reset_pending();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
